// File: rtl/pulse_width_generator.sv
// Programmable pulse/burst generator. On an accepted start it drives
// pulse_out high for width_ms milliseconds, repeating num_pulses times with
// gap_ms milliseconds low between pulses, and closes each burst with a
// one-cycle done_tick. All outputs are registered.
module pulse_width_generator #(
  parameter int unsigned CYCLES_PER_MS = 50_000,
  parameter int unsigned MS_W          = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [MS_W-1:0] width_ms,
  input  logic [MS_W-1:0] gap_ms,
  input  logic [7:0]      num_pulses,
  output logic            pulse_out,
  output logic            ready,
  output logic            done_tick,
  output logic            aborted,
  output logic [19:0]     count,
  output logic [MS_W-1:0] elapsed_ms,
  output logic [7:0]      pulses_sent
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [19:0]     LAST_CNT = 20'(CYCLES_PER_MS - 1);
  localparam logic [MS_W-1:0] MS_ONE   = MS_W'(1);

  state_t          state_q, state_d;
  logic [MS_W-1:0] width_q, width_d;
  logic [MS_W-1:0] gap_q, gap_d;
  logic [7:0]      num_q, num_d;
  logic            pulse_q, pulse_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            aborted_q, aborted_d;
  logic [19:0]     count_q, count_d;
  logic [MS_W-1:0] elapsed_q, elapsed_d;
  logic [7:0]      pulses_q, pulses_d;

  logic            ms_wrap;
  logic [19:0]     count_inc;
  logic [MS_W-1:0] elapsed_inc;
  logic [7:0]      pulses_inc;

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    gap_d     = gap_q;
    num_d     = num_q;
    pulse_d   = pulse_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    count_d   = count_q;
    elapsed_d = elapsed_q;
    pulses_d  = pulses_q;

    ms_wrap     = (count_q == LAST_CNT);
    count_inc   = ms_wrap ? '0 : count_q + 20'd1;
    elapsed_inc = ms_wrap ? elapsed_q + MS_ONE : elapsed_q;
    pulses_inc  = pulses_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          width_d   = width_ms;
          gap_d     = gap_ms;
          num_d     = num_pulses;
          pulses_d  = '0;
          aborted_d = 1'b0;
          count_d   = '0;
          elapsed_d = '0;
          ready_d   = 1'b0;
          if (width_ms == '0 || num_pulses == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_HIGH;
            pulse_d = 1'b1;
          end
        end
      end

      S_HIGH: begin
        if (abort) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          pulse_d   = 1'b0;
        end else if (ms_wrap && elapsed_q == width_q - MS_ONE) begin
          pulses_d  = pulses_inc;
          count_d   = '0;
          elapsed_d = '0;
          pulse_d   = 1'b0;
          if (pulses_inc == num_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          count_d   = count_inc;
          elapsed_d = elapsed_inc;
        end
      end

      S_GAP: begin
        // A zero gap still spends one low cycle here so pulses stay distinct.
        if (abort) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          pulse_d   = 1'b0;
        end else if (gap_q == '0 || (ms_wrap && elapsed_q == gap_q - MS_ONE)) begin
          state_d   = S_HIGH;
          pulse_d   = 1'b1;
          count_d   = '0;
          elapsed_d = '0;
        end else begin
          count_d   = count_inc;
          elapsed_d = elapsed_inc;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        pulse_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      width_q   <= '0;
      gap_q     <= '0;
      num_q     <= '0;
      pulse_q   <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      count_q   <= '0;
      elapsed_q <= '0;
      pulses_q  <= '0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      gap_q     <= gap_d;
      num_q     <= num_d;
      pulse_q   <= pulse_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      count_q   <= count_d;
      elapsed_q <= elapsed_d;
      pulses_q  <= pulses_d;
    end
  end

  assign pulse_out   = pulse_q;
  assign ready       = ready_q;
  assign done_tick   = done_q;
  assign aborted     = aborted_q;
  assign count       = count_q;
  assign elapsed_ms  = elapsed_q;
  assign pulses_sent = pulses_q;

endmodule

// File: tb/tb_pulse_width_generator.sv
// Scoreboard bench for pulse_width_generator with CYCLES_PER_MS=10.
// Stimulus pushes expected high/gap run lengths and done records; a monitor
// measures pulse_out runs and checks each done_tick against the queues.
module tb_pulse_width_generator;

  localparam int CPM = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] width_ms = '0;
  logic [15:0] gap_ms = '0;
  logic [7:0]  num_pulses = '0;
  logic        pulse_out, ready, done_tick, aborted;
  logic [19:0] count;
  logic [15:0] elapsed_ms;
  logic [7:0]  pulses_sent;

  pulse_width_generator #(
    .CYCLES_PER_MS(CPM),
    .MS_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .width_ms(width_ms), .gap_ms(gap_ms), .num_pulses(num_pulses),
    .pulse_out(pulse_out), .ready(ready), .done_tick(done_tick),
    .aborted(aborted), .count(count), .elapsed_ms(elapsed_ms),
    .pulses_sent(pulses_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pulses;
    int ab;
    int cnt;
    int el;
    int prev_p;
    int prev_r;
  } done_rec_t;

  int        exp_hi_q[$];
  int        exp_gap_q[$];
  done_rec_t exp_done_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor state
  int prev_p = 0;
  int prev_r = 1;
  int run = 0;
  int in_gap = 0;
  int check_ready = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_p = 0;
      prev_r = 1;
      run = 0;
      in_gap = 0;
      check_ready = 0;
    end else begin
      if (check_ready != 0) chk("ready_after_done", ready, 1);
      check_ready = 0;
      if (int'(pulse_out) != prev_p) begin
        if (prev_p == 1) begin
          if (exp_hi_q.size() == 0) chk("unexpected_high_run", run, 0);
          else chk("high_len", run, exp_hi_q.pop_front());
          in_gap = 1;
        end else if (in_gap != 0) begin
          if (exp_gap_q.size() == 0) chk("unexpected_gap_run", run, 0);
          else chk("gap_len", run, exp_gap_q.pop_front());
        end
        run = 1;
      end else begin
        run++;
      end
      if (done_tick) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          done_rec_t r;
          r = exp_done_q.pop_front();
          chk("done_pulses_sent", pulses_sent, r.pulses);
          chk("done_aborted", aborted, r.ab);
          chk("done_count", count, r.cnt);
          chk("done_elapsed", elapsed_ms, r.el);
          chk("done_pulse_low", pulse_out, 0);
          chk("done_ready_low", ready, 0);
          chk("done_prev_pulse", prev_p, r.prev_p);
          chk("done_prev_ready", prev_r, r.prev_r);
        end
        in_gap = 0;
        check_ready = 1;
        done_cnt++;
      end
      prev_p = int'(pulse_out);
      prev_r = int'(ready);
    end
  end

  task automatic push_burst(input int w, input int g, input int n);
    done_rec_t r;
    if (w == 0 || n == 0) begin
      r = '{pulses: 0, ab: 0, cnt: 0, el: 0, prev_p: 0, prev_r: 1};
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_hi_q.push_back(w * CPM);
        if (i < n - 1) exp_gap_q.push_back(g == 0 ? 1 : g * CPM);
      end
      r = '{pulses: n, ab: 0, cnt: 0, el: 0, prev_p: 1, prev_r: 0};
    end
    exp_done_q.push_back(r);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  // Inputs are scrambled after acceptance to confirm the fields were latched.
  task automatic issue_start(input int w, input int g, input int n);
    wait_ready();
    width_ms   = 16'(w);
    gap_ms     = 16'(g);
    num_pulses = 8'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    width_ms   = 16'($urandom_range(1, 9));
    gap_ms     = 16'($urandom_range(1, 9));
    num_pulses = 8'($urandom_range(1, 9));
  endtask

  task automatic wait_done();
    int base = done_cnt;
    int k = 0;
    while (done_cnt == base && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    if (done_cnt == base) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pulse_out"}, pulse_out, 0);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_done_tick"}, done_tick, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_elapsed"}, elapsed_ms, 0);
    chk({tag, "_pulses_sent"}, pulses_sent, 0);
  endtask

  initial begin
    done_rec_t r;
    int d0;

    #2 rst = 1'b1;
    #3 chk_reset_vals("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single 3 ms pulse.
    push_burst(3, 2, 1);
    issue_start(3, 2, 1);
    chk("pulse_rise_at_accept", pulse_out, 1);
    chk("ready_low_at_accept", ready, 0);
    wait_done();
    chk("single_pulses_sent", pulses_sent, 1);

    // Burst of three 2 ms pulses with 1 ms gaps.
    push_burst(2, 1, 3);
    issue_start(2, 1, 3);
    wait_done();
    chk("burst_pulses_sent_held", pulses_sent, 3);

    // Zero-length requests.
    push_burst(0, 2, 3);
    issue_start(0, 2, 3);
    wait_done();
    push_burst(4, 2, 0);
    issue_start(4, 2, 0);
    wait_done();
    chk("zero_aborted", aborted, 0);

    // Abort at cycle 15 of a 3 ms pulse, with an ignored start mid-pulse.
    exp_hi_q.push_back(16);
    r = '{pulses: 0, ab: 1, cnt: 5, el: 1, prev_p: 1, prev_r: 0};
    exp_done_q.push_back(r);
    issue_start(3, 2, 2);
    repeat (3) begin @(posedge clk); #1; end
    width_ms = 16'd1; num_pulses = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_pulse_low", pulse_out, 0);
    chk("abort_done_tick", done_tick, 1);
    wait_done();
    chk("aborted_held", aborted, 1);
    chk("abort_count_frozen", count, 5);

    // start and abort together in IDLE: not accepted.
    wait_ready();
    width_ms = 16'd2; num_pulses = 8'd1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_ready", ready, 1);
    chk("start_abort_pulse", pulse_out, 0);
    chk("start_abort_aborted_held", aborted, 1);
    @(posedge clk); #1;
    chk("start_abort_no_done", done_tick, 0);

    // Zero gap keeps pulses distinct with a single low cycle.
    push_burst(1, 0, 2);
    issue_start(1, 0, 2);
    wait_done();

    // Loopback-style width sweep.
    for (int w = 1; w <= 5; w++) begin
      push_burst(w, 1, 1);
      issue_start(w, 1, 1);
      wait_done();
    end

    // Asynchronous reset mid-pulse: immediate reset values, no done_tick.
    issue_start(2, 1, 1);
    repeat (7) begin @(posedge clk); #1; end
    chk("pre_reset_pulse_high", pulse_out, 1);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    chk("no_done_after_reset", done_cnt, d0);
    chk("post_reset_pulse_low", pulse_out, 0);

    chk("exp_high_queue_empty", exp_hi_q.size(), 0);
    chk("exp_gap_queue_empty", exp_gap_q.size(), 0);
    chk("exp_done_queue_empty", exp_done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
